// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side buffer and its FIFO.
package uart_pkg;

   // Width of one UART data byte.
   localparam int UART_DW = 8;

   // States of the transmit issue state machine.
   typedef enum logic [1:0] {
      TXB_IDLE      = 2'd0,
      TXB_ISSUE     = 2'd1,
      TXB_WAIT_BUSY = 2'd2,
      TXB_WAIT_DONE = 2'd3
   } txb_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_buffer_if.sv
// Bundle of the CPU write port, the status flags and the transmitter handshake.
// The master side is whoever owns the CPU bus and the transmitter.
// The slave side is the buffer.
interface uart_tx_buffer_if #(
   parameter int DEPTH = 16
) ();
   import uart_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic               wr_en;
   logic [UART_DW-1:0] wr_data;
   logic               full;
   logic               empty;
   logic [AW:0]        level;
   logic               overflow;
   logic               tx_start;
   logic [UART_DW-1:0] tx_data;
   logic               tx_busy;
   logic               tx_idle;

   modport master (
      output wr_en, wr_data, tx_busy,
      input  full, empty, level, overflow, tx_start, tx_data, tx_idle
   );

   modport slave (
      input  wr_en, wr_data, tx_busy,
      output full, empty, level, overflow, tx_start, tx_data, tx_idle
   );

endinterface : uart_tx_buffer_if

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with a fall-through head read.
// Pointers are one bit wider than the address, so full and empty fall out of the pointer difference.
// The RX path reuses this FIFO.
module sync_fifo #(
   parameter int DEPTH = 16,   // power of two, >= 2
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overflow_o
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level;
   logic             overflow_q, overflow_d;
   logic             full, empty, push, pop;

   assign level = wr_ptr_q - rd_ptr_q;
   assign full  = (level == DEPTH_L);
   assign empty = (level == '0);

   // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a pop.
   assign pop  = rd_en_i & ~empty;
   assign push = wr_en_i & (~full | pop);

   // Pointer advance and overflow detection for the current cycle.
   always_comb begin
      wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
      overflow_d = wr_en_i & full & ~pop;
   end

   // Pointer and overflow registers. Reset takes priority over any write in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage write. Contents are left alone on reset.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

   // The head is read combinationally so that a pop can capture it in the same cycle.
   assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign full_o     = full;
   assign empty_o    = empty;
   assign level_o    = level;
   assign overflow_o = overflow_q;

endmodule : sync_fifo

// File: rtl/uart_tx_buffer.sv
// Byte queue in front of the UART transmitter.
// The queue issues one byte per transmitter frame, paced by the transmitter's busy output.
// tx_start is a one-cycle pulse, and tx_data holds its value until the next pop.
module uart_tx_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH = 16    // power of two, >= 2
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_buffer_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   txb_state_t         state_q, state_d;
   logic               tx_start_q, tx_start_d;
   logic [UART_DW-1:0] tx_data_q, tx_data_d;
   logic               pop;
   logic [UART_DW-1:0] head;
   logic               empty;
   logic [AW:0]        level;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (UART_DW)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (bus.wr_en),
      .wr_data_i  (bus.wr_data),
      .rd_en_i    (pop),
      .rd_data_o  (head),
      .full_o     (bus.full),
      .empty_o    (empty),
      .level_o    (level),
      .overflow_o (bus.overflow)
   );

   // Issue sequencing. A byte is popped only while the transmitter is idle.
   // After that the FSM waits for busy to rise and then fall before it looks at the queue again.
   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      pop       = 1'b0;
      unique case (state_q)
         TXB_IDLE: begin
            if (!empty && !bus.tx_busy) begin
               pop       = 1'b1;
               tx_data_d = head;
               state_d   = TXB_ISSUE;
            end
         end
         TXB_ISSUE: begin
            state_d = TXB_WAIT_BUSY;
         end
         TXB_WAIT_BUSY: begin
            if (bus.tx_busy) begin
               state_d = TXB_WAIT_DONE;
            end
         end
         TXB_WAIT_DONE: begin
            if (!bus.tx_busy) begin
               state_d = TXB_IDLE;
            end
         end
         default: begin
            state_d = TXB_IDLE;
         end
      endcase
      tx_start_d = (state_d == TXB_ISSUE);
   end

   // State, start pulse and data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= TXB_IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign bus.empty    = empty;
   assign bus.level    = level;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_idle  = empty & (state_q == TXB_IDLE) & ~bus.tx_busy;

endmodule : uart_tx_buffer
